// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage: funct3 codes, FSM encoding
// and the request legality / alignment helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Store funct3 values alias the signed load codes, so one table covers both.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      LH, LHU: return addr_lo[0];
      LW:      return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {SB, SH, SW};
    else    return funct3 inside {LB, LH, LW, LBU, LHU};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, data-memory and response signals of the access stage.
// slave is the access unit's view; master is the surrounding pipeline/memory.
interface mem_access_unit_if #(parameter int ADDR_W = 6);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic              rsp_is_load;
  logic [31:0]       rsp_mem_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic [2:0]        rsp_funct3;
  logic              rsp_misalign;
  logic              rsp_bus_err;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           rsp_valid, rsp_is_load, rsp_mem_data, rsp_addr, rsp_funct3,
           rsp_misalign, rsp_bus_err
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           rsp_valid, rsp_is_load, rsp_mem_data, rsp_addr, rsp_funct3,
           rsp_misalign, rsp_bus_err
  );

endinterface

// File: rtl/mem_access_unit_store_lane_align.sv
// Maps a low-aligned store operand onto the byte lanes of a 32-bit word.
// Lane data is replicated so any enabled lane already carries the right bytes.
module store_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  always_comb begin
    be        = 4'b1111;
    lane_data = wdata;
    case (funct3)
      SB: begin
        be        = 4'b0001 << addr_lo;
        lane_data = {4{wdata[7:0]}};
      end
      SH: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        lane_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: validates one load/store at a time, drives the
// req/ack memory port with a timeout and returns a one-cycle response.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic               req_bad;
  logic               timeout;
  logic [3:0]         st_be;
  logic [31:0]        st_data;

  logic               mem_we_q;
  logic [3:0]         mem_be_q;
  logic [ADDR_W-3:0]  mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               rsp_is_load_q;
  logic [31:0]        rsp_mem_data_q;
  logic [ADDR_W-1:0]  rsp_addr_q;
  logic [2:0]         rsp_funct3_q;
  logic               rsp_misalign_q;
  logic               rsp_bus_err_q;

  store_lane_align u_align (
    .funct3    (bus.req_funct3),
    .addr_lo   (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .be        (st_be),
    .lane_data (st_data)
  );

  assign req_bad = !is_legal(bus.req_we, bus.req_funct3) ||
                   is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  // A late ack in the final allowed cycle still completes normally.
  assign timeout = !bus.mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = req_bad ? RESP : ACCESS;
      ACCESS:  if (bus.mem_ack || timeout) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.mem_req   = (state == ACCESS);
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt       <= '0;
      mem_we_q       <= 1'b0;
      mem_be_q       <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp_is_load_q  <= 1'b0;
      rsp_mem_data_q <= '0;
      rsp_addr_q     <= '0;
      rsp_funct3_q   <= '0;
      rsp_misalign_q <= 1'b0;
      rsp_bus_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          rsp_addr_q     <= bus.req_addr;
          rsp_funct3_q   <= bus.req_funct3;
          rsp_is_load_q  <= !bus.req_we;
          rsp_mem_data_q <= '0;
          rsp_bus_err_q  <= 1'b0;
          rsp_misalign_q <= req_bad;
          wait_cnt       <= '0;
          if (!req_bad) begin
            mem_we_q    <= bus.req_we;
            mem_addr_q  <= bus.req_addr[ADDR_W-1:2];
            mem_be_q    <= bus.req_we ? st_be : 4'b1111;
            mem_wdata_q <= bus.req_we ? st_data : 32'd0;
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            if (rsp_is_load_q) rsp_mem_data_q <= bus.mem_rdata;
            mem_we_q <= 1'b0;
            wait_cnt <= '0;
          end else if (timeout) begin
            rsp_bus_err_q  <= 1'b1;
            rsp_mem_data_q <= '0;
            mem_we_q       <= 1'b0;
            wait_cnt       <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we       = mem_we_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.rsp_is_load  = rsp_is_load_q;
  assign bus.rsp_mem_data = rsp_mem_data_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_funct3   = rsp_funct3_q;
  assign bus.rsp_misalign = rsp_misalign_q;
  assign bus.rsp_bus_err  = rsp_bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, misalignment,
// timeout, ack-at-timeout, back-to-back issue and mid-access reset.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  mem_access_unit_if #(.ADDR_W(6)) bus ();

  mem_access_unit #(.ADDR_W(6), .TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; returns in the cycle after acceptance.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                               input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    fails  = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 6'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;

    #2;
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_mem_be", bus.mem_be, 0);
    checkOutput("rst_rsp_addr", bus.rsp_addr, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // LW 0x08 with ack in first ACCESS cycle
    applyStimulus(1'b0, LW, 6'h08, 32'h0);
    checkOutput("lw_mem_req", bus.mem_req, 1);
    checkOutput("lw_mem_we", bus.mem_we, 0);
    checkOutput("lw_mem_addr", bus.mem_addr, 2);
    checkOutput("lw_mem_be", bus.mem_be, 4'b1111);
    checkOutput("lw_req_ready", bus.req_ready, 0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("lw_rsp_valid", bus.rsp_valid, 1);
    checkOutput("lw_rsp_data", bus.rsp_mem_data, 32'hDEADBEEF);
    checkOutput("lw_rsp_addr", bus.rsp_addr, 6'h08);
    checkOutput("lw_rsp_funct3", bus.rsp_funct3, 2);
    checkOutput("lw_rsp_is_load", bus.rsp_is_load, 1);
    checkOutput("lw_mem_req_drop", bus.mem_req, 0);
    tick();
    checkOutput("lw_rsp_pulse", bus.rsp_valid, 0);

    // SB 0x0D
    applyStimulus(1'b1, SB, 6'h0D, 32'hFFFFFFA5);
    checkOutput("sb_mem_we", bus.mem_we, 1);
    checkOutput("sb_mem_addr", bus.mem_addr, 3);
    checkOutput("sb_mem_be", bus.mem_be, 4'b0010);
    checkOutput("sb_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h55555555;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("sb_rsp_valid", bus.rsp_valid, 1);
    checkOutput("sb_rsp_data", bus.rsp_mem_data, 0);
    checkOutput("sb_rsp_is_load", bus.rsp_is_load, 0);
    checkOutput("sb_rsp_addr", bus.rsp_addr, 6'h0D);
    tick();

    // SH 0x06
    applyStimulus(1'b1, SH, 6'h06, 32'hABCD1234);
    checkOutput("sh_mem_addr", bus.mem_addr, 1);
    checkOutput("sh_mem_be", bus.mem_be, 4'b1100);
    checkOutput("sh_mem_wdata", bus.mem_wdata, 32'h12341234);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("sh_rsp_valid", bus.rsp_valid, 1);
    checkOutput("sh_rsp_misalign", bus.rsp_misalign, 0);
    tick();

    // Misaligned LW 0x05
    applyStimulus(1'b0, LW, 6'h05, 32'h0);
    checkOutput("mis_mem_req", bus.mem_req, 0);
    checkOutput("mis_rsp_valid", bus.rsp_valid, 1);
    checkOutput("mis_rsp_misalign", bus.rsp_misalign, 1);
    tick();

    // Illegal load funct3 3
    applyStimulus(1'b0, 3'd3, 6'h00, 32'h0);
    checkOutput("ill_mem_req", bus.mem_req, 0);
    checkOutput("ill_rsp_valid", bus.rsp_valid, 1);
    checkOutput("ill_rsp_misalign", bus.rsp_misalign, 1);
    tick();

    // Ack while idle must not produce a response
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("idle_ack_rsp_valid", bus.rsp_valid, 0);
    checkOutput("idle_ack_ready", bus.req_ready, 1);

    // LB with no ack: timeout after 15 request cycles
    bus.mem_rdata = 32'h77777777;
    applyStimulus(1'b0, LB, 6'h11, 32'h0);
    checkOutput("to_misalign_cleared", bus.rsp_misalign, 0);
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      tick();
    end
    checkOutput("to_req_cycles", n, 15);
    checkOutput("to_rsp_valid", bus.rsp_valid, 1);
    checkOutput("to_bus_err", bus.rsp_bus_err, 1);
    checkOutput("to_rsp_data", bus.rsp_mem_data, 0);
    tick();

    // Ack exactly in the 15th ACCESS cycle wins over timeout
    applyStimulus(1'b0, LW, 6'h10, 32'h0);
    checkOutput("late_bus_err_cleared", bus.rsp_bus_err, 0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("late_mem_req", bus.mem_req, 1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("late_rsp_valid", bus.rsp_valid, 1);
    checkOutput("late_bus_err", bus.rsp_bus_err, 0);
    checkOutput("late_rsp_data", bus.rsp_mem_data, 32'hCAFEF00D);
    tick();

    // Back-to-back with req_valid held high
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LW;
    bus.req_addr   = 6'h04;
    tick();
    checkOutput("b2b_access_ready", bus.req_ready, 0);
    checkOutput("b2b_mem_addr1", bus.mem_addr, 1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h01020304;
    tick();
    bus.mem_ack    = 1'b0;
    bus.req_we     = 1'b1;
    bus.req_funct3 = SW;
    bus.req_addr   = 6'h0C;
    bus.req_wdata  = 32'h11223344;
    checkOutput("b2b_resp_ready", bus.req_ready, 0);
    checkOutput("b2b_rsp_data1", bus.rsp_mem_data, 32'h01020304);
    tick();
    checkOutput("b2b_idle_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("b2b_mem_req2", bus.mem_req, 1);
    checkOutput("b2b_mem_we2", bus.mem_we, 1);
    checkOutput("b2b_mem_addr2", bus.mem_addr, 3);
    checkOutput("b2b_mem_wdata2", bus.mem_wdata, 32'h11223344);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("b2b_rsp_valid2", bus.rsp_valid, 1);
    checkOutput("b2b_rsp_data2", bus.rsp_mem_data, 0);
    tick();

    // Reset in the middle of ACCESS
    applyStimulus(1'b0, LW, 6'h20, 32'h0);
    checkOutput("rstmid_mem_req_before", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_mem_req", bus.mem_req, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rstmid_ready", bus.req_ready, 1);
    checkOutput("rstmid_rsp_valid", bus.rsp_valid, 0);
    applyStimulus(1'b0, LW, 6'h24, 32'h0);
    checkOutput("rstmid_mem_addr", bus.mem_addr, 9);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("rstmid_rsp_valid2", bus.rsp_valid, 1);
    checkOutput("rstmid_rsp_data", bus.rsp_mem_data, 32'h0BADF00D);
    checkOutput("rstmid_rsp_addr", bus.rsp_addr, 6'h24);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
